// File: rtl/gate_truth_table_checker.sv
// rtl/gate_truth_table_checker.sv - sequential truth-table exerciser for two-input gates
module gate_truth_table_checker #(
   parameter int SETTLE_CYCLES = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [2:0] gate_sel,
   input  logic       y,
   output logic       a,
   output logic       b,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_vec,
   output logic [2:0] err_count
);

   localparam logic [3:0] SETTLE = 4'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRIVE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t     state;
   logic [2:0] sel_q;
   logic [1:0] idx;
   logic [3:0] cnt;
   logic       exp_y;
   logic       mismatch;
   logic [3:0] fail_next;
   logic [2:0] err_next;

   // Expected response of the latched gate for the current combination,
   // plus the result vectors as they will look if this cycle is the sample.
   always_comb begin
      exp_y = 1'b0;
      case (sel_q)
         3'd0:    exp_y = idx[1] & idx[0];
         3'd1:    exp_y = idx[1] | idx[0];
         3'd2:    exp_y = ~idx[1];
         3'd3:    exp_y = ~(idx[1] & idx[0]);
         3'd4:    exp_y = ~(idx[1] | idx[0]);
         3'd5:    exp_y = idx[1] ^ idx[0];
         3'd6:    exp_y = ~(idx[1] ^ idx[0]);
         default: exp_y = 1'b0;
      endcase
      mismatch  = (y != exp_y);
      fail_next = fail_vec | (4'(mismatch) << idx);
      err_next  = err_count + 3'(mismatch);
   end

   // Control FSM: accept start, walk the four combinations, pulse done.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         sel_q     <= 3'd0;
         idx       <= 2'd0;
         cnt       <= 4'd0;
         a         <= 1'b0;
         b         <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail_vec  <= 4'd0;
         err_count <= 3'd0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  if (gate_sel == 3'd7) begin
                     // Unknown gate: report total failure without driving stimulus.
                     state     <= ST_DONE;
                     done      <= 1'b1;
                     fail_vec  <= 4'hF;
                     err_count <= 3'd4;
                     pass      <= 1'b0;
                  end else begin
                     state     <= ST_DRIVE;
                     sel_q     <= gate_sel;
                     fail_vec  <= 4'd0;
                     err_count <= 3'd0;
                     pass      <= 1'b0;
                     idx       <= 2'd0;
                     cnt       <= 4'd0;
                     a         <= 1'b0;
                     b         <= 1'b0;
                     busy      <= 1'b1;
                  end
               end
            end
            ST_DRIVE: begin
               if (cnt == SETTLE) begin
                  fail_vec  <= fail_next;
                  err_count <= err_next;
                  cnt       <= 4'd0;
                  if (idx == 2'd3) begin
                     state <= ST_DONE;
                     done  <= 1'b1;
                     busy  <= 1'b0;
                     a     <= 1'b0;
                     b     <= 1'b0;
                     pass  <= (fail_next == 4'd0);
                     idx   <= 2'd0;
                  end else begin
                     idx    <= idx + 2'd1;
                     {a, b} <= idx + 2'd1;
                  end
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule
